// File: rtl/aurora_rx_pkg.sv
// Shared types and header helpers for the Aurora RX 64b/66b block-sync path.
package aurora_rx_pkg;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } bsync_state_e;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_CTRL = 2'b10;

    function automatic logic is_good_hdr(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/aurora_block_sync_lane.sv
// One lane of 64b/66b block sync: header hunt, gearbox/serdes slip and lock monitoring.
module aurora_block_sync_lane
    import aurora_rx_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned ERR_THRESH = 16,
    parameter int unsigned WAIT_CNT   = 4,
    parameter int unsigned GBOX_SLIPS = 66
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] hdr_i,
    input  logic       hdr_valid_i,
    output logic       gearbox_slip_o,
    output logic       serdes_slip_o,
    output logic       lock_o,
    output logic       lock_lost_o
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WW = $clog2(WINDOW + 1);
    localparam int unsigned EW = $clog2(ERR_THRESH + 1);
    localparam int unsigned TW = $clog2(WAIT_CNT + 1);
    localparam int unsigned SW = $clog2(GBOX_SLIPS + 1);

    bsync_state_e  state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [WW-1:0] win_q, win_d;
    logic [EW-1:0] err_q, err_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [SW-1:0] slip_q, slip_d;
    logic          gs_q, gs_d;
    logic          ss_q, ss_d;
    logic          lock_q, lock_d;
    logic          lost_q, lost_d;
    logic          good_hdr;

    assign good_hdr = is_good_hdr(hdr_i);

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        win_d   = win_q;
        err_d   = err_q;
        wait_d  = wait_q;
        slip_d  = slip_q;
        lock_d  = lock_q;
        gs_d    = 1'b0;
        ss_d    = 1'b0;
        lost_d  = 1'b0;
        if (hdr_valid_i) begin
            case (state_q)
                HUNT: begin
                    if (good_hdr) begin
                        if (good_q == GW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            lock_d  = 1'b1;
                            good_d  = '0;
                            slip_d  = '0;
                            win_d   = '0;
                            err_d   = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        good_d  = '0;
                        wait_d  = '0;
                        state_d = SLIP_WAIT;
                        if (slip_q == SW'(GBOX_SLIPS - 1)) begin
                            ss_d   = 1'b1;
                            slip_d = '0;
                        end else begin
                            gs_d   = 1'b1;
                            slip_d = slip_q + SW'(1);
                        end
                    end
                end
                SLIP_WAIT: begin
                    if (wait_q == TW'(WAIT_CNT - 1)) begin
                        wait_d  = '0;
                        state_d = HUNT;
                    end else begin
                        wait_d = wait_q + TW'(1);
                    end
                end
                LOCKED: begin
                    // Threshold is tested before the window wrap so it wins on the last header.
                    if (!good_hdr && (err_q == EW'(ERR_THRESH - 1))) begin
                        state_d = HUNT;
                        lock_d  = 1'b0;
                        lost_d  = 1'b1;
                        good_d  = '0;
                        win_d   = '0;
                        err_d   = '0;
                        slip_d  = '0;
                    end else if (win_q == WW'(WINDOW - 1)) begin
                        win_d = '0;
                        err_d = '0;
                    end else begin
                        win_d = win_q + WW'(1);
                        if (!good_hdr) begin
                            err_d = err_q + EW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q <= HUNT;
            good_q  <= '0;
            win_q   <= '0;
            err_q   <= '0;
            wait_q  <= '0;
            slip_q  <= '0;
            lock_q  <= 1'b0;
            gs_q    <= 1'b0;
            ss_q    <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            win_q   <= win_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            slip_q  <= slip_d;
            lock_q  <= lock_d;
            gs_q    <= gs_d;
            ss_q    <= ss_d;
            lost_q  <= lost_d;
        end
    end

    assign gearbox_slip_o = gs_q;
    assign serdes_slip_o  = ss_q;
    assign lock_o         = lock_q;
    assign lock_lost_o    = lost_q;

endmodule

// File: rtl/aurora_rx_block_sync.sv
// Multi-lane 64b/66b block-sync controller: per-lane sync FSMs plus lock_all reduction.
// Optional per-lane lock-loss / serdes-slip statistics when AURORA_BSYNC_STATS_EN is defined.
module aurora_rx_block_sync #(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned ERR_THRESH = 16,
    parameter int unsigned SLIP_WAIT  = 4,
    parameter int unsigned GBOX_SLIPS = 66
) (
    input  logic                   clk_rx_i,
    input  logic                   rst_i,
    input  logic [NUM_LANES-1:0]   lane_en_i,
    input  logic [2*NUM_LANES-1:0] hdr_i,
    input  logic [NUM_LANES-1:0]   hdr_valid_i,
    output logic [NUM_LANES-1:0]   gearbox_slip_o,
    output logic [NUM_LANES-1:0]   serdes_slip_o,
    output logic [NUM_LANES-1:0]   lock_o,
    output logic [NUM_LANES-1:0]   lock_lost_o,
    output logic                   lock_all_o
`ifdef AURORA_BSYNC_STATS_EN
    ,
    output logic [16*NUM_LANES-1:0] stat_lock_loss_o,
    output logic [16*NUM_LANES-1:0] stat_serdes_slip_o
`endif
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        aurora_block_sync_lane #(
            .LOCK_CNT   (LOCK_CNT),
            .WINDOW     (WINDOW),
            .ERR_THRESH (ERR_THRESH),
            .WAIT_CNT   (SLIP_WAIT),
            .GBOX_SLIPS (GBOX_SLIPS)
        ) u_lane (
            .clk_i          (clk_rx_i),
            .rst_i          (rst_i),
            .en_i           (lane_en_i[g]),
            .hdr_i          (hdr_i[2*g +: 2]),
            .hdr_valid_i    (hdr_valid_i[g]),
            .gearbox_slip_o (gearbox_slip_o[g]),
            .serdes_slip_o  (serdes_slip_o[g]),
            .lock_o         (lock_o[g]),
            .lock_lost_o    (lock_lost_o[g])
        );
    end

    // Disabled lanes do not block lock_all; no enabled lane means no lock.
    assign lock_all_o = (|lane_en_i) & (&(lock_o | ~lane_en_i));

`ifdef AURORA_BSYNC_STATS_EN
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_stats
        logic [15:0] loss_q;
        logic [15:0] sslip_q;

        // Saturating event counters; survive lane disable, cleared only by rst_i.
        always_ff @(posedge clk_rx_i) begin
            if (rst_i) begin
                loss_q  <= '0;
                sslip_q <= '0;
            end else begin
                if (lock_lost_o[g] && (loss_q != 16'hFFFF)) begin
                    loss_q <= loss_q + 16'd1;
                end
                if (serdes_slip_o[g] && (sslip_q != 16'hFFFF)) begin
                    sslip_q <= sslip_q + 16'd1;
                end
            end
        end

        assign stat_lock_loss_o[16*g +: 16]   = loss_q;
        assign stat_serdes_slip_o[16*g +: 16] = sslip_q;
    end
`endif

endmodule
